// File: rtl/result_streamer.sv
// result_streamer: captures a completed result matrix from the systolic
// fetcher on a rising comp_ready and streams it out element by element,
// row-major, over a valid/ready handshake.
module result_streamer #(
   parameter int DATA_WIDTH = 8,
   parameter int ARRAY_A_W  = 4,
   parameter int ARRAY_W_L  = 4
) (
   input  logic                                                   clk,
   input  logic                                                   reset_n,
   input  logic                                                   comp_ready,
   input  logic [0:ARRAY_A_W-1][0:ARRAY_W_L-1][2*DATA_WIDTH-1:0] in_data,
   output logic                                                   out_valid,
   input  logic                                                   out_ready,
   output logic [2*DATA_WIDTH-1:0]                                out_data,
   output logic [3:0]                                             out_row,
   output logic [3:0]                                             out_col,
   output logic                                                   out_last,
   output logic                                                   busy,
   output logic                                                   overrun,
   input  logic                                                   clr_overrun
);

   localparam logic [3:0] LAST_ROW = 4'(ARRAY_A_W - 1);
   localparam logic [3:0] LAST_COL = 4'(ARRAY_W_L - 1);

   typedef enum logic {IDLE, STREAM} state_t;

   state_t     state, state_d;
   logic [3:0] row, row_d;
   logic [3:0] col, col_d;
   logic       comp_ready_q;
   logic       start;
   logic       capture;
   logic       at_last;

   logic [0:ARRAY_A_W-1][0:ARRAY_W_L-1][2*DATA_WIDTH-1:0] buffer;

   // A start is a fresh rising edge of the completion level; the delayed copy
   // resets high so a level already present at reset release is not a start.
   assign start   = comp_ready && !comp_ready_q;
   assign at_last = (row == LAST_ROW) && (col == LAST_COL);

   // Control state: FSM, element counters, edge detector and sticky overrun.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state        <= IDLE;
         row          <= '0;
         col          <= '0;
         comp_ready_q <= 1'b1;
         overrun      <= 1'b0;
      end else begin
         state        <= state_d;
         row          <= row_d;
         col          <= col_d;
         comp_ready_q <= comp_ready;
         // A new overrun event wins over a simultaneous clear.
         if (start && state == STREAM)
            overrun <= 1'b1;
         else if (clr_overrun)
            overrun <= 1'b0;
      end
   end

   // Matrix buffer: loaded only on capture, never reset.
   always_ff @(posedge clk) begin
      if (capture)
         buffer <= in_data;
   end

   // Next-state and counter logic; starts in IDLE only, walks row-major on transfers.
   always_comb begin
      state_d = state;
      row_d   = row;
      col_d   = col;
      capture = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               capture = 1'b1;
               state_d = STREAM;
               row_d   = '0;
               col_d   = '0;
            end
         end
         STREAM: begin
            if (out_ready) begin
               if (at_last) begin
                  state_d = IDLE;
                  row_d   = '0;
                  col_d   = '0;
               end else if (col == LAST_COL) begin
                  col_d = '0;
                  row_d = row + 4'd1;
               end else begin
                  col_d = col + 4'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            row_d   = '0;
            col_d   = '0;
         end
      endcase
   end

   // Output view: buffer element at (row, col) while streaming, all zero otherwise.
   always_comb begin
      out_valid = (state == STREAM);
      busy      = (state == STREAM);
      out_row   = '0;
      out_col   = '0;
      out_last  = 1'b0;
      out_data  = '0;
      if (state == STREAM) begin
         out_row  = row;
         out_col  = col;
         out_last = at_last;
         for (int r = 0; r < ARRAY_A_W; r++) begin
            for (int c = 0; c < ARRAY_W_L; c++) begin
               if (row == r[3:0] && col == c[3:0])
                  out_data = buffer[r][c];
            end
         end
      end
   end

endmodule

// File: tb/tb_result_streamer.sv
// tb_result_streamer: directed bench for result_streamer with hand-computed
// expectations (element (r,c) of the test matrix is 16*r+c).
module tb_result_streamer;

   logic                        clk;
   logic                        reset_n;
   logic                        comp_ready;
   logic [0:3][0:3][15:0]       in_data;
   logic                        out_valid;
   logic                        out_ready;
   logic [15:0]                 out_data;
   logic [3:0]                  out_row;
   logic [3:0]                  out_col;
   logic                        out_last;
   logic                        busy;
   logic                        overrun;
   logic                        clr_overrun;

   int checks = 0;
   int errors = 0;

   result_streamer #(.DATA_WIDTH(8), .ARRAY_A_W(4), .ARRAY_W_L(4)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .comp_ready  (comp_ready),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_row     (out_row),
      .out_col     (out_col),
      .out_last    (out_last),
      .busy        (busy),
      .overrun     (overrun),
      .clr_overrun (clr_overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic load_pattern();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            in_data[r][c] = 16'(16 * r + c);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_valid"},   32'(out_valid), 32'd0);
      chk({tag, "_busy"},    32'(busy),      32'd0);
      chk({tag, "_data"},    32'(out_data),  32'd0);
      chk({tag, "_row"},     32'(out_row),   32'd0);
      chk({tag, "_col"},     32'(out_col),   32'd0);
      chk({tag, "_last"},    32'(out_last),  32'd0);
   endtask

   // Drive a 0->1 on comp_ready and confirm out_valid follows one edge later.
   task automatic start_capture(input string tag);
      comp_ready = 1'b0;
      step();
      comp_ready = 1'b1;
      chk({tag, "_prevalid"}, 32'(out_valid), 32'd0);
      step();
      chk({tag, "_valid1"}, 32'(out_valid), 32'd1);
      chk({tag, "_busy1"},  32'(busy),      32'd1);
   endtask

   // Consume the stream; mode 0 = ready always, mode 1 = ready 1,0,0,1.
   // ovr_at >= 0 raises comp_ready when that element is presented.
   // first_k lets the walk start mid-stream.
   task automatic run_stream(input string tag, input int mode, input int ovr_at, input int first_k);
      int k   = first_k;
      int cyc = 0;
      logic rdy;
      while (k < 16 && cyc < 100) begin
         if (mode == 0) rdy = 1'b1;
         else           rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
         out_ready = rdy;
         if (ovr_at >= 0 && k == ovr_at) comp_ready = 1'b1;
         chk({tag, "_v"},    32'(out_valid), 32'd1);
         chk({tag, "_d"},    32'(out_data),  32'(16 * (k / 4) + (k % 4)));
         chk({tag, "_r"},    32'(out_row),   32'(k / 4));
         chk({tag, "_c"},    32'(out_col),   32'(k % 4));
         chk({tag, "_last"}, 32'(out_last),  32'(k == 15));
         step();
         if (rdy) k++;
         cyc++;
      end
      out_ready = 1'b1;
      chk({tag, "_count"}, 32'(k), 32'd16);
      chk_idle({tag, "_end"});
   endtask

   initial begin
      reset_n     = 1'b0;
      comp_ready  = 1'b0;
      out_ready   = 1'b1;
      clr_overrun = 1'b0;
      in_data     = '0;
      step();
      step();
      chk_idle("rst");
      chk("rst_overrun", 32'(overrun), 32'd0);
      reset_n = 1'b1;
      load_pattern();
      step();

      // Basic stream at full rate; comp_ready stays high afterwards.
      start_capture("s1");
      run_stream("s1", 0, -1, 0);
      for (int i = 0; i < 3; i++) step();
      chk("hold_high_no_recapture", 32'(out_valid), 32'd0);
      chk("hold_high_no_overrun",   32'(overrun),   32'd0);

      // Backpressure pattern.
      start_capture("s2");
      run_stream("s2", 1, -1, 0);

      // Overrun at element 5, then clear.
      start_capture("s3");
      comp_ready = 1'b0;
      run_stream("s3", 0, 5, 0);
      chk("ovr_set", 32'(overrun), 32'd1);
      comp_ready = 1'b0;
      step();
      chk("ovr_sticky", 32'(overrun), 32'd1);
      clr_overrun = 1'b1;
      step();
      clr_overrun = 1'b0;
      chk("ovr_clr", 32'(overrun), 32'd0);

      // Input changes after capture must not reach the stream.
      start_capture("s4");
      in_data = {16{16'hFFFF}};
      run_stream("s4", 0, -1, 0);
      load_pattern();

      // comp_ready high through reset release: no capture until a fresh edge.
      comp_ready = 1'b1;
      reset_n    = 1'b0;
      step();
      step();
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_high_nocap", 32'(out_valid), 32'd0);
      end
      start_capture("s5");
      run_stream("s5", 0, -1, 0);

      // Abort mid-stream with reset after 7 transfers, overrun pending.
      start_capture("s6");
      comp_ready = 1'b0;
      out_ready  = 1'b1;
      step();
      step();
      step();
      comp_ready = 1'b1;
      step();
      step();
      step();
      step();
      chk("s6_ovr",  32'(overrun), 32'd1);
      chk("s6_pos",  32'(out_data), 32'h13);
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      chk_idle("abort");
      chk("abort_overrun", 32'(overrun), 32'd0);
      step();
      chk("abort_stays_idle", 32'(out_valid), 32'd0);
      start_capture("s7");
      run_stream("s7", 0, -1, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
